pipe_stage_reg: RTL

Parametrised pipeline stage register for the five-stage MIPS core. It replaces the per-stage fixed-width latches with one configurable block. It carries PC, N data lanes, destination register, control bits and Tuse/Tnew hazard tags, and adds the following over the fixed latches:
- stall (hold);
- flush (bubble insertion);
- a valid bit;
- Tnew countdown while held;
- a forwarding-ready flag for the hazard unit.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/tnew_counter.sv | 45 ++++
 rtl/pipe_stage_reg.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and saturating Tnew decrement for the pipeline stage registers
package pipe_pkg;

    localparam int TNEW_W_DEF    = 2;
    localparam int TNEW_MAX_W    = 16;

    localparam int CTRL_MEMTOREG = 0;
    localparam int CTRL_MEMWRITE = 1;
    localparam int CTRL_JAL      = 2;

    // Callers zero-extend into and truncate out of the wide form, so any TNEW_W up to TNEW_MAX_W works.
    function automatic logic [TNEW_MAX_W-1:0] sat_dec(input logic [TNEW_MAX_W-1:0] x);
        return (x != '0) ? x - TNEW_MAX_W'(1) : '0;
    endfunction

endpackage

// File: rtl/tnew_counter.sv
// rtl/tnew_counter.sv - Tnew register: load with decrement, countdown while held, clear on bubble
module tnew_counter
    import pipe_pkg::*;
#(
    parameter int TNEW_W = TNEW_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic              hold_i,
    input  logic              valid_i,
    input  logic [TNEW_W-1:0] tnew_i,
    output logic [TNEW_W-1:0] tnew_o,
    output logic              zero_o,
    output logic              busy_o
);

    logic [TNEW_W-1:0] tnew_q;
    logic [TNEW_W-1:0] tnew_d;

    always_comb begin
        tnew_d = tnew_q;
        if (clear_i) begin
            tnew_d = '0;
        end else if (load_i) begin
            tnew_d = TNEW_W'(sat_dec(TNEW_MAX_W'(tnew_i)));
        end else if (hold_i) begin
            tnew_d = TNEW_W'(sat_dec(TNEW_MAX_W'(tnew_q)));
        end
    end

    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tnew_q <= '0;
        end else begin
            tnew_q <= tnew_d;
        end
    end

    assign tnew_o = tnew_q;
    assign zero_o = (tnew_q == '0);
    assign busy_o = valid_i & ~zero_o;

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - MIPS pipeline stage register with stall, flush, Tnew countdown and forward-ready flag
// Optional stall/bubble counters enabled by PIPE_STAGE_REG_STATS_EN.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_DATA = 2,
    parameter int REG_AW   = 5,
    parameter int CTRL_W   = 4,
    parameter int TNEW_W   = TNEW_W_DEF
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       Stall,
    input  logic                       Flush,
    input  logic                       Valid_In,
    input  logic [31:0]                Pc_In,
    input  logic [NUM_DATA*DATA_W-1:0] Data_In,
    input  logic [REG_AW-1:0]          WriteReg_In,
    input  logic                       RegWrite_In,
    input  logic [CTRL_W-1:0]          Ctrl_In,
    input  logic [TNEW_W-1:0]          Tuse_Rs_In,
    input  logic [TNEW_W-1:0]          Tuse_Rt_In,
    input  logic [TNEW_W-1:0]          Tnew_In,
    output logic                       Valid_Out,
    output logic [31:0]                Pc_Out,
    output logic [NUM_DATA*DATA_W-1:0] Data_Out,
    output logic [REG_AW-1:0]          WriteReg_Out,
    output logic                       RegWrite_Out,
    output logic [CTRL_W-1:0]          Ctrl_Out,
    output logic [TNEW_W-1:0]          Tuse_Rs_Out,
    output logic [TNEW_W-1:0]          Tuse_Rt_Out,
    output logic [TNEW_W-1:0]          Tnew_Out,
    output logic                       Fwd_Ready_Out,
    output logic                       Busy_Out
`ifdef PIPE_STAGE_REG_STATS_EN
    ,
    output logic [31:0]                Stall_Cnt,
    output logic [31:0]                Bubble_Cnt
`endif
);

    logic                       valid_q,    valid_d;
    logic [31:0]                pc_q,       pc_d;
    logic [NUM_DATA*DATA_W-1:0] data_q,     data_d;
    logic [REG_AW-1:0]          wreg_q,     wreg_d;
    logic                       regwrite_q, regwrite_d;
    logic [CTRL_W-1:0]          ctrl_q,     ctrl_d;
    logic [TNEW_W-1:0]          tuse_rs_q,  tuse_rs_d;
    logic [TNEW_W-1:0]          tuse_rt_q,  tuse_rt_d;

    logic bubble;
    logic load;
    logic tnew_zero;

    // A load of a non-valid instruction is treated exactly like a flush.
    assign bubble = Flush | (~Stall & ~Valid_In);
    assign load   = ~Flush & ~Stall & Valid_In;

    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        data_d     = data_q;
        wreg_d     = wreg_q;
        regwrite_d = regwrite_q;
        ctrl_d     = ctrl_q;
        tuse_rs_d  = tuse_rs_q;
        tuse_rt_d  = tuse_rt_q;
        if (bubble) begin
            valid_d    = 1'b0;
            pc_d       = '0;
            data_d     = '0;
            wreg_d     = '0;
            regwrite_d = 1'b0;
            ctrl_d     = '0;
            tuse_rs_d  = '0;
            tuse_rt_d  = '0;
        end else if (load) begin
            valid_d    = 1'b1;
            pc_d       = Pc_In;
            data_d     = Data_In;
            wreg_d     = WriteReg_In;
            regwrite_d = RegWrite_In;
            ctrl_d     = Ctrl_In;
            tuse_rs_d  = Tuse_Rs_In;
            tuse_rt_d  = Tuse_Rt_In;
        end
    end

    always_ff @(negedge Clk or negedge Reset) begin
        if (!Reset) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            data_q     <= '0;
            wreg_q     <= '0;
            regwrite_q <= 1'b0;
            ctrl_q     <= '0;
            tuse_rs_q  <= '0;
            tuse_rt_q  <= '0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            data_q     <= data_d;
            wreg_q     <= wreg_d;
            regwrite_q <= regwrite_d;
            ctrl_q     <= ctrl_d;
            tuse_rs_q  <= tuse_rs_d;
            tuse_rt_q  <= tuse_rt_d;
        end
    end

    tnew_counter #(
        .TNEW_W (TNEW_W)
    ) u_tnew (
        .clk_i   (Clk),
        .rst_ni  (Reset),
        .clear_i (bubble),
        .load_i  (load),
        .hold_i  (Stall),
        .valid_i (valid_q),
        .tnew_i  (Tnew_In),
        .tnew_o  (Tnew_Out),
        .zero_o  (tnew_zero),
        .busy_o  (Busy_Out)
    );

    assign Valid_Out     = valid_q;
    assign Pc_Out        = pc_q;
    assign Data_Out      = data_q;
    assign WriteReg_Out  = wreg_q;
    assign RegWrite_Out  = regwrite_q;
    assign Ctrl_Out      = ctrl_q;
    assign Tuse_Rs_Out   = tuse_rs_q;
    assign Tuse_Rt_Out   = tuse_rt_q;
    assign Fwd_Ready_Out = valid_q & regwrite_q & (wreg_q != '0) & tnew_zero;

`ifdef PIPE_STAGE_REG_STATS_EN
    logic [31:0] stall_cnt_q,  stall_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (Stall & ~Flush & valid_q) stall_cnt_d = stall_cnt_q + 32'd1;
        if (bubble) bubble_cnt_d = bubble_cnt_q + 32'd1;
    end

    always_ff @(negedge Clk or negedge Reset) begin
        if (!Reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign Stall_Cnt  = stall_cnt_q;
    assign Bubble_Cnt = bubble_cnt_q;
`endif

endmodule
